// File: rtl/edge_event_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | edge_event_arbiter_pkg                                             |
// | Shared detect-mode / event-kind encodings and round-robin helper.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package edge_event_arbiter_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] kind_t;

  localparam mode_t c_MODE_OFF  = 2'b00;
  localparam mode_t c_MODE_RISE = 2'b01;
  localparam mode_t c_MODE_FALL = 2'b10;
  localparam mode_t c_MODE_BOTH = 2'b11;

  localparam kind_t c_KIND_NONE = 2'b00;
  localparam kind_t c_KIND_RISE = 2'b01;
  localparam kind_t c_KIND_FALL = 2'b10;

  // Distance of channel ch from the search start, in round-robin order.
  function automatic int rr_offset(input int ch, input int start, input int n);
    return (ch + n - start) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
// +--------------------------------------------------------------------+
// | edge_event_arbiter_if                                              |
// | Channel inputs, event handshake and overflow signals.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface edge_event_arbiter_if #(
  parameter int N_CH = 4
);
  import edge_event_arbiter_pkg::*;

  logic [N_CH-1:0]         din;
  logic [2*N_CH-1:0]       mode;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [$clog2(N_CH)-1:0] evt_ch;
  kind_t                   evt_kind;
  logic [N_CH-1:0]         ovf;
  logic [N_CH-1:0]         ovf_clr;

  modport slave (
    input  din, mode, evt_ready, ovf_clr,
    output evt_valid, evt_ch, evt_kind, ovf
  );

  modport master (
    output din, mode, evt_ready, ovf_clr,
    input  evt_valid, evt_ch, evt_kind, ovf
  );

endinterface

`default_nettype wire

// File: rtl/edge_event_arbiter_chan.sv
// +--------------------------------------------------------------------+
// | edge_event_chan                                                    |
// | One channel: edge detect, mode qualify, pending slot, overflow.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module edge_event_chan
  import edge_event_arbiter_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  din,
  input  wire mode_t mode,
  input  wire logic  drain,
  input  wire logic  ovf_clr,
  output logic       pending,
  output kind_t      kind,
  output logic       ovf
);

  logic  r_prev;
  logic  r_primed;
  logic  r_pending;
  kind_t r_kind;
  logic  r_ovf;

  logic  w_rise;
  logic  w_fall;
  logic  w_qual;
  logic  w_ovf_evt;
  kind_t w_kind;

  assign w_rise = r_primed & ~r_prev &  din;
  assign w_fall = r_primed &  r_prev & ~din;
  assign w_qual = (w_rise & ((mode == c_MODE_RISE) | (mode == c_MODE_BOTH))) |
                  (w_fall & ((mode == c_MODE_FALL) | (mode == c_MODE_BOTH)));
  assign w_kind = w_rise ? c_KIND_RISE : c_KIND_FALL;

  // A slot being drained this cycle counts as free for the incoming edge.
  assign w_ovf_evt = w_qual & r_pending & ~drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= 1'b0;
      r_primed  <= 1'b0;
      r_pending <= 1'b0;
      r_kind    <= c_KIND_NONE;
      r_ovf     <= 1'b0;
    end else begin
      r_prev   <= din;
      r_primed <= 1'b1;
      if (w_qual && (!r_pending || drain)) begin
        r_pending <= 1'b1;
        r_kind    <= w_kind;
      end else if (drain) begin
        r_pending <= 1'b0;
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign pending = r_pending;
  assign kind    = r_kind;
  assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// +--------------------------------------------------------------------+
// | edge_event_arbiter                                                 |
// | Round-robin arbitration of per-channel edge events into one slot.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_,
  edge_event_arbiter_if.slave  bus
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_drain;
  logic [N_CH-1:0] w_ovf;
  kind_t           w_kind [N_CH];

  logic            w_load;
  logic            w_any;
  logic [CH_W-1:0] w_win;
  int              w_start;
  int              w_best;

  logic            r_valid;
  logic [CH_W-1:0] r_ch;
  kind_t           r_kind;
  logic [CH_W-1:0] r_last;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      edge_event_chan u_chan (
        .clk     (clk),
        .rst     (rst_),
        .din     (bus.din[gi]),
        .mode    (bus.mode[2*gi+1 -: 2]),
        .drain   (w_drain[gi]),
        .ovf_clr (bus.ovf_clr[gi]),
        .pending (w_pend[gi]),
        .kind    (w_kind[gi]),
        .ovf     (w_ovf[gi])
      );
    end
  endgenerate

  assign w_load = ~r_valid | bus.evt_ready;

  // Pick the pending channel closest after the last grant.
  always_comb begin
    w_start = (int'(r_last) + 1) % N_CH;
    w_best  = N_CH;
    w_any   = 1'b0;
    w_win   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_pend[CH_W'(c)] && (rr_offset(c, w_start, N_CH) < w_best)) begin
        w_best = rr_offset(c, w_start, N_CH);
        w_any  = 1'b1;
        w_win  = CH_W'(c);
      end
    end
  end

  always_comb begin
    w_drain = '0;
    if (w_load && w_any) begin
      w_drain[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_kind  <= c_KIND_NONE;
      r_last  <= CH_W'(N_CH - 1);
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_ch   <= w_win;
        r_kind <= w_kind[w_win];
        r_last <= w_win;
      end
    end
  end

  assign bus.evt_valid = r_valid;
  assign bus.evt_ch    = r_ch;
  assign bus.evt_kind  = r_kind;
  assign bus.ovf       = w_ovf;

endmodule

`default_nettype wire

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of monitored input channels (2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
REQ-004 din  input  N_CH  asynchronous-free channel levels, already synchronous to clk.
REQ-005 mode  input  2*N_CH  per-channel detect mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-006 evt_valid  output  1  event slot holds an event.
REQ-007 evt_ready  input  1  consumer accepts the event when high with evt_valid.
REQ-008 evt_ch  output  $clog2(N_CH)  channel index of the held event.
REQ-009 evt_kind  output  2  10 falling, 01 rising; 00 and 11 are never emitted.
REQ-010 ovf  output  N_CH  sticky per-channel overflow flags.
REQ-011 ovf_clr  input  N_CH  per-channel overflow clear strobe.

Function
REQ-012 Each channel SHALL register the previous din sample; rise = prev 0, cur 1; fall = prev 1, cur 0; level-held 00/11 yields no event.
REQ-013 An edge SHALL be qualified by mode; an edge of a disabled kind is discarded with no side effect.
REQ-014 On the first clk edge after reset release, each channel SHALL load prev from din without generating an event (prime cycle).
REQ-015 Each channel SHALL hold one pending slot (flag + kind); a qualified edge on an empty slot sets it at the detecting edge.
REQ-016 A qualified edge on an occupied slot (not being drained that cycle) SHALL be dropped, the held kind kept, and ovf[i] set.
REQ-017 If a channel's pending slot is drained into the output in the same cycle a new qualified edge arrives, the new edge SHALL occupy the slot with no overflow.
REQ-018 The output slot SHALL load when evt_valid=0 or (evt_valid && evt_ready); it takes the round-robin winner among pending channels and clears that channel's pending flag.
REQ-019 Round robin: search starts at (last granted + 1) mod N_CH; pointer updates only on a load; after reset the pointer SHALL favour channel 0.
REQ-020 While evt_valid=1 and evt_ready=0, evt_ch and evt_kind SHALL remain stable and no pending slot is drained.
REQ-021 Latency: edge on din sampled at edge t sets pending at t; evt_valid SHALL rise at edge t+1 if the output slot is free and the channel wins.
REQ-022 Throughput SHALL be one event per cycle under continuous evt_ready=1.
REQ-023 ovf_clr[i] SHALL clear ovf[i]; a simultaneous overflow on channel i wins (ovf[i] stays 1).
REQ-024 Changing mode[i] SHALL affect only subsequent edges; an already-pending event is still delivered.

Reset
REQ-025 rst_ high SHALL clear evt_valid, evt_ch, evt_kind, ovf, all pending flags and prev registers to 0, set the RR pointer so channel 0 has priority, and arm the prime cycle.
REQ-026 Reset asserted mid-handshake SHALL discard the held and pending events; nothing is emitted afterward until a new edge.

Structure
REQ-027 Shared package SHALL hold the mode encodings (OFF/RISE/FALL/BOTH) and the kind encodings (RISE=01, FALL=10).
REQ-028 Per-channel detect + pending slot SHALL be a sub-module edge_event_chan instantiated N_CH times; arbitration and output slot live in the top.

Verification
REQ-029 Reset with din=4'b1111, mode all 11, release -> no evt_valid during the next 3 cycles.
REQ-030 ch2 0->1, mode=01, evt_ready=1 -> evt_valid one cycle later, evt_ch=2, evt_kind=01, for exactly one cycle.
REQ-031 ch0..ch3 rise simultaneously, evt_ready=1 -> events on consecutive cycles with evt_ch 0,1,2,3.
REQ-032 evt_ready=0, ch1 rises then falls two cycles later (mode 11) -> evt_ch=1/kind=01 held stable, fall sits pending, ovf=0; a third ch1 edge before drain -> ovf[1]=1, after ready: only kinds 01 then 10 emitted.
REQ-033 ovf_clr[1] pulsed in the same cycle as a new ch1 overflow -> ovf[1] stays 1; pulsed alone -> ovf[1]=0 next cycle.
REQ-034 rst_ asserted while evt_valid=1 with evt_ready=0 and two channels pending -> evt_valid=0 next cycle, no event emitted afterward without new edges.
